// File: rtl/pipe_pkg.sv
// Shared constants and types for the elastic pipeline register chain.
// Optional feature macro: PIPE_REG_CHAIN_PARITY_EN (per-stage even parity).
package pipe_pkg;

    localparam int DEF_DATA_W = 26;
    localparam int DEF_DEPTH  = 2;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] data;
`ifdef PIPE_REG_CHAIN_PARITY_EN
        logic                  parity;
`endif
    } stage_t;

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle for pipe_reg_chain: upstream push, downstream pop, flush, occupancy.
// Optional feature macro: PIPE_REG_CHAIN_PARITY_EN adds the sticky par_err signal.
interface pipe_reg_chain_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    // A word moves on a rising edge exactly when valid & ready are both high on
    // that side; in_ready already includes !flush, while out_valid is raw state
    // and must be ignored by the consumer during a flush cycle.
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     flush;
    logic [cnt_w(DEPTH)-1:0]  count;
`ifdef PIPE_REG_CHAIN_PARITY_EN
    logic                     par_err;
`endif

    modport slave (
        input  in_valid, in_data, out_ready, flush,
`ifdef PIPE_REG_CHAIN_PARITY_EN
        output par_err,
`endif
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
`ifdef PIPE_REG_CHAIN_PARITY_EN
        input  par_err,
`endif
        input  in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_stage.sv
// One elastic stage: a valid bit plus a data word with load/clear/hold control.
// Data only changes on load, so an emptied stage keeps its last word.
module pipe_stage #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage elastic pipeline register with valid/ready, synchronous flush and occupancy count.
// Optional feature macro: PIPE_REG_CHAIN_PARITY_EN (even parity carried per stage, sticky par_err).
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_reg_chain_if.slave  bus
);

    localparam int CNT_W = cnt_w(DEPTH);
`ifdef PIPE_REG_CHAIN_PARITY_EN
    localparam int              SW        = DATA_W + 1;
    localparam logic [SW-1:0]   STAGE_RST = {^RESET_VAL, RESET_VAL};
`else
    localparam int              SW        = DATA_W;
    localparam logic [SW-1:0]   STAGE_RST = RESET_VAL;
`endif

    logic [DEPTH-1:0] v, adv, load, clear;
    logic [SW-1:0]    q [DEPTH];
    logic [SW-1:0]    in_word;
    logic             accept, consume, hole;
    logic [CNT_W-1:0] count_q, count_d;

    // A valid stage advances iff the output is consuming or any stage above it
    // is empty; this is the recursive advance rule unrolled from the output side.
    always_comb begin
        adv  = '0;
        hole = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v[i] & hole;
            hole   = hole | ~v[i];
        end
    end

    assign bus.in_ready = ~bus.flush & (~v[0] | adv[0]);
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = adv[DEPTH-1] & ~bus.flush;

    always_comb begin
        load     = '0;
        clear    = '0;
        load[0]  = accept;
        clear[0] = adv[0] | bus.flush;
        for (int i = 1; i < DEPTH; i++) begin
            load[i]  = adv[i-1] & ~bus.flush;
            clear[i] = adv[i] | bus.flush;
        end
    end

`ifdef PIPE_REG_CHAIN_PARITY_EN
    assign in_word = {^bus.in_data, bus.in_data};
`else
    assign in_word = bus.in_data;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [SW-1:0] d_in;
        if (i == 0) begin : g_head
            assign d_in = in_word;
        end else begin : g_body
            assign d_in = q[i-1];
        end

        pipe_stage #(
            .W         (SW),
            .RESET_VAL (STAGE_RST)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[i]),
            .clear_i (clear[i]),
            .d_i     (d_in),
            .valid_o (v[i]),
            .q_o     (q[i])
        );
    end

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (accept & ~consume) begin
            count_d = count_q + 1'b1;
        end else if (~accept & consume) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = q[DEPTH-1][DATA_W-1:0];
    assign bus.count     = count_q;

`ifdef PIPE_REG_CHAIN_PARITY_EN
    // Sticky: only rst_n clears it, flush deliberately leaves it alone.
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (v[DEPTH-1] & bus.out_ready &
            ((^q[DEPTH-1][DATA_W-1:0]) != q[DEPTH-1][DATA_W])) begin
            par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: a DEPTH=2/26-bit and a DEPTH=4/8-bit instance
// checked against a FIFO-order reference model (parity checks under PIPE_REG_CHAIN_PARITY_EN).
`timescale 1ns/1ps
module tb_pipe_reg_chain;
    import pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipe_reg_chain_if #(.DATA_W(26), .DEPTH(2)) if2 ();
    pipe_reg_chain_if #(.DATA_W(8),  .DEPTH(4)) if4 ();

    pipe_reg_chain #(.DATA_W(26), .DEPTH(2), .RESET_VAL(26'h0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    pipe_reg_chain #(.DATA_W(8), .DEPTH(4), .RESET_VAL(8'h0)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    // ---------------- scoreboard ----------------
    logic [25:0] exp2_q[$];
    int          age2_q[$];
    logic [7:0]  exp4_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    bit          lat_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: the chain is a FIFO of capacity DEPTH; a word accepted at
    // edge N leaves no earlier than edge N+DEPTH.
    always @(negedge clk) begin
        logic [25:0] w;
        int a;
        if (!rst_n) begin
            exp2_q.delete();
            age2_q.delete();
        end else begin
            check("count2", 32'(if2.count), 32'(exp2_q.size()));
            check("in_ready2", 32'(if2.in_ready),
                  32'(!if2.flush && (exp2_q.size() < 2 || if2.out_ready)));
            if (exp2_q.size() == 0) check("ovalid_empty2", 32'(if2.out_valid), 32'(0));
            if (exp2_q.size() == 2) check("ovalid_full2", 32'(if2.out_valid), 32'(1));
            if (if2.flush) begin
                exp2_q.delete();
                age2_q.delete();
            end else begin
                if (if2.out_valid && if2.out_ready && exp2_q.size() > 0) begin
                    w = exp2_q.pop_front();
                    a = age2_q.pop_front();
                    check("data2", 32'(if2.out_data), 32'(w));
                    if (lat_chk) check("latency2", 32'(cyc + 1 - a), 32'(2));
                end
                if (if2.in_valid && if2.in_ready) begin
                    exp2_q.push_back(if2.in_data);
                    age2_q.push_back(cyc + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] w;
        if (!rst_n) begin
            exp4_q.delete();
        end else begin
            check("count4", 32'(if4.count), 32'(exp4_q.size()));
            check("in_ready4", 32'(if4.in_ready),
                  32'(!if4.flush && (exp4_q.size() < 4 || if4.out_ready)));
            if (exp4_q.size() == 0) check("ovalid_empty4", 32'(if4.out_valid), 32'(0));
            if (exp4_q.size() == 4) check("ovalid_full4", 32'(if4.out_valid), 32'(1));
            if (if4.flush) begin
                exp4_q.delete();
            end else begin
                if (if4.out_valid && if4.out_ready && exp4_q.size() > 0) begin
                    w = exp4_q.pop_front();
                    check("data4", 32'(if4.out_data), 32'(w));
                end
                if (if4.in_valid && if4.in_ready) exp4_q.push_back(if4.in_data);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send2(input logic [25:0] w);
        if2.in_valid = 1'b1;
        if2.in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if2.in_ready) begin
                @(posedge clk);
                #1;
                if2.in_valid = 1'b0;
                return;
            end
        end
        if2.in_valid = 1'b0;
        timeout("send2");
    endtask

    task automatic send4(input logic [7:0] w);
        if4.in_valid = 1'b1;
        if4.in_data  = w;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if4.in_ready) begin
                @(posedge clk);
                #1;
                if4.in_valid = 1'b0;
                return;
            end
        end
        if4.in_valid = 1'b0;
        timeout("send4");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int start;
        logic [25:0] pw;
        if2.in_valid = 0; if2.in_data = '0; if2.out_ready = 0; if2.flush = 0;
        if4.in_valid = 0; if4.in_data = '0; if4.out_ready = 0; if4.flush = 0;
        #1;
        check("rst_ovalid", 32'(if2.out_valid), 32'(0));
        check("rst_odata", 32'(if2.out_data), 32'(0));
        check("rst_count", 32'(if2.count), 32'(0));
        check("rst_inready", 32'(if2.in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef PIPE_REG_CHAIN_PARITY_EN
        @(negedge clk);
        check("par_err_rst", 32'(if2.par_err), 32'(0));
        tick();
`endif

        // Streaming: 1 word/cycle, each consumed DEPTH edges after acceptance.
        if2.out_ready = 1'b1;
        lat_chk = 1'b1;
        start = cyc;
        for (int i = 1; i <= 5; i++) send2(26'(i));
        check("stream_rate", 32'(cyc - start), 32'(5));
        repeat (4) tick();
        lat_chk = 1'b0;

        // Backpressure then pass-through ready.
        if2.out_ready = 1'b0;
        send2(26'h3FFFFFF);
        send2(26'h1555555);
        if2.in_valid = 1'b1;
        if2.in_data  = 26'h2AAAAAA;
        @(negedge clk);
        check("bp_count", 32'(if2.count), 32'(2));
        check("bp_inready", 32'(if2.in_ready), 32'(0));
        repeat (2) tick();
        if2.out_ready = 1'b1;
        @(negedge clk);
        check("bp_passthru", 32'(if2.in_ready), 32'(1));
        check("bp_head", 32'(if2.out_data), 32'(26'h3FFFFFF));
        tick();
        if2.in_valid  = 1'b0;
        if2.out_ready = 1'b0;
        @(negedge clk);
        check("bp_count_kept", 32'(if2.count), 32'(2));

        // Flush while full dominates the offered input word.
        tick();
        if2.flush    = 1'b1;
        if2.in_valid = 1'b1;
        if2.in_data  = 26'h0000ABC;
        @(negedge clk);
        check("flush_inready", 32'(if2.in_ready), 32'(0));
        tick();
        if2.flush     = 1'b0;
        if2.in_valid  = 1'b0;
        if2.out_ready = 1'b1;
        @(negedge clk);
        check("flush_count", 32'(if2.count), 32'(0));
        check("flush_ovalid", 32'(if2.out_valid), 32'(0));
        repeat (3) tick();
        check("flush_no_capture", 32'(if2.out_valid), 32'(0));

        // DEPTH=4 fill and drain.
        if4.out_ready = 1'b0;
        send4(8'h11); send4(8'h22); send4(8'h33); send4(8'h44);
        @(negedge clk);
        check("d4_full_count", 32'(if4.count), 32'(4));
        check("d4_full_inready", 32'(if4.in_ready), 32'(0));
        tick();
        if4.out_ready = 1'b1;
        begin
            bit drained = 1'b0;
            for (int k = 0; k < 20 && !drained; k++) begin
                @(negedge clk);
                if (if4.count == 0) drained = 1'b1;
            end
            if (!drained) timeout("d4_drain");
        end
        check("d4_drained_ovalid", 32'(if4.out_valid), 32'(0));
        tick();

        // Asynchronous reset mid-stream with two words held.
        if2.out_ready = 1'b0;
        send2(26'h0123456);
        send2(26'h0654321);
        check("pre_rst_count", 32'(if2.count), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ovalid", 32'(if2.out_valid), 32'(0));
        check("arst_odata", 32'(if2.out_data), 32'(0));
        check("arst_count", 32'(if2.count), 32'(0));
        check("arst_inready", 32'(if2.in_ready), 32'(1));
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic on both instances, rare flushes.
        for (int n = 0; n < 600; n++) begin
            if2.in_valid  = 1'($urandom_range(0, 1));
            if2.in_data   = 26'($urandom);
            if2.out_ready = ($urandom_range(0, 9) < 7);
            if2.flush     = ($urandom_range(0, 39) == 0);
            if4.in_valid  = 1'($urandom_range(0, 1));
            if4.in_data   = 8'($urandom);
            if4.out_ready = ($urandom_range(0, 9) < 5);
            if4.flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        if2.in_valid = 0; if2.flush = 0; if2.out_ready = 1;
        if4.in_valid = 0; if4.flush = 0; if4.out_ready = 1;
        repeat (8) tick();

`ifdef PIPE_REG_CHAIN_PARITY_EN
        // Corrupt the output-stage word behind the parity bit's back.
        if2.out_ready = 1'b0;
        pw = 26'h0000AB0;
        send2(pw);
        tick();
        force u_dut2.g_stage[1].u_stage.data_q = {^pw, pw ^ 26'h1};
        exp2_q[0] = pw ^ 26'h1;
        @(negedge clk);
        check("par_err_pre", 32'(if2.par_err), 32'(0));
        tick();
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        release u_dut2.g_stage[1].u_stage.data_q;
        @(negedge clk);
        check("par_err_set", 32'(if2.par_err), 32'(1));
        tick();
        if2.flush = 1'b1;
        tick();
        if2.flush = 1'b0;
        @(negedge clk);
        check("par_err_flush", 32'(if2.par_err), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("par_err_rst_clr", 32'(if2.par_err), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
`else
        pw = '0;
        check("pw_unused", 32'(pw), 32'(if2.out_data & 26'h0));
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised elastic pipeline register: DEPTH stages of DATA_W-bit registers.
- Each stage has a valid bit and valid/ready handshake, plus synchronous flush and an occupancy count.
- Successor to the fixed-width, always-capturing D flip-flop register; used between processor pipeline stages (IF/ID, ID/EX) where stall and bubble insertion are needed.

Parameters:
- DATA_W, 26, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VAL, 0, reset value of every stage data register (DATA_W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  DATA_W  payload.
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  last stage data register.
- flush  in  1  synchronous clear of all valid bits.
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: all stage valid bits 0; all stage data = RESET_VAL. So out_valid=0, out_data=RESET_VAL, count=0, in_ready=1.
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i], d[i].
- Advance terms:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - adv[i] = v[i] & (!v[i+1] | adv[i+1]).
- Ready: in_ready = !v[0] | adv[0], computed combinationally, so throughput is 1 word/cycle with no bubbles.
- Per-stage update each edge:
  - Stage 0 loads in_data and sets v[0]=1 when in_valid & in_ready.
  - Otherwise stage 0 clears v[0] if adv[0]; if neither, it holds.
  - Stage i>0 loads d[i-1] and sets v[i]=1 when adv[i-1]; otherwise it clears if adv[i], else holds.
- Data registers load only on a transfer; they retain their value when a stage empties.
- Latency: in_data accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH cycles of register delay with no backpressure.
- Backpressure: with out_ready=0, words compact toward the output. in_ready falls after DEPTH words are held and rises in the same cycle out_ready returns high (pass-through ready).
- Full chain with out_ready=1 and in_valid=1: shift by one, in_ready=1, count unchanged.
- Flush:
  - Flush high at an edge clears every v[i] and sets count to 0.
  - Flush dominates a simultaneous input or output transfer: in_ready is forced 0 while flush=1, and out_valid is still reported from the current state, but the downstream must ignore it.
  - Data registers are not cleared by flush.
- count: registered; +1 on accept, -1 on output consume, unchanged when both occur, 0 on flush/reset. Never exceeds DEPTH.
- Reset asserted mid-operation: immediate clear regardless of clk; no data survives.
- DEPTH=1: a single register; in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: PIPE_REG_CHAIN_PARITY_EN.
- Defined:
  - Each stage stores an extra even-parity bit, computed on in_data at stage 0 and carried along the chain.
  - At the output, a mismatch while out_valid & out_ready sets a sticky output port par_err (1 bit), cleared only by rst_n (reset value 0).
  - par_err is not affected by flush.
- Undefined: no parity storage, port par_err absent; behaviour otherwise identical.

Decomposition:
- Package pipe_pkg:
  - default DATA_W/DEPTH constants.
  - a clog2-based count-width function.
  - a stage_t struct {valid, data[, parity]} typedef.
- One sub-module pipe_stage: a single valid+data register with load/clear/hold and async reset. pipe_reg_chain generates DEPTH instances and the advance/ready logic.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 words held -> out_valid=0, out_data=0, count=0, in_ready=1, asynchronously before the next clk edge.
- Streaming (DEPTH=2): out_ready=1, in_data=0x0000001..0x0000005 on consecutive cycles -> each word appears on out_data exactly 2 edges later, in order, in_ready constantly 1.
- Backpressure: out_ready=0, push 0x3FFFFFF and 0x1555555 -> count=2, in_ready=0, third word 0x2AAAAAA held upstream. Raise out_ready -> 0x3FFFFFF consumed, 0x2AAAAAA accepted in the same cycle, count stays 2.
- Flush: chain full (count=2), flush=1 with in_valid=1 and in_data=0x0000ABC -> next cycle count=0, out_valid=0, 0x0000ABC not captured.
- DEPTH=4, DATA_W=8 instance: push 4 words with out_ready=0 -> count=4, in_ready=0. Drain -> words 0x11,0x22,0x33,0x44 out in order, count reaches 0.
- With PIPE_REG_CHAIN_PARITY_EN: force a bit flip in stage-1 data via hierarchical force -> par_err=1 after consume, stays 1 after flush, cleared by rst_n.
